// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// The PARITY encoding is always reserved; it is only used when SERIAL_FRAME_TX_PARITY_EN is defined.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: emits a one-clock tick on the last clock of every DIV-clock bit period.
// The counter is held at zero while disabled so every frame starts on a clean bit boundary.
module bit_tick_gen
    import serial_frame_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic res,
    input  logic en,
    output logic tick
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [TW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == TW'(DIV - 1));
    assign tick = en && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB-first, stop bit.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             txd,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             last_bit;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .res  (res),
        .en   (busy_q),
        .tick (tick)
    );

    assign din_ready = (state_q == IDLE);
    assign last_bit  = (bit_cnt_q == BW'(WIDTH - 1));
    assign txd       = txd_q;
    assign busy      = busy_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    state_d = START;
                    shreg_d = din;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (last_bit) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so txd and busy leave the flops glitch-free.
    always_comb begin
        txd_d  = IDLE_LEVEL;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:  txd_d = START_BIT;
            DATA:   txd_d = shreg_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: txd_d = parity_q;
`endif
            STOP:   txd_d = STOP_BIT;
            default: txd_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= IDLE_LEVEL;
            busy_q    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: a DIV=4 instance and a DIV=1 instance share clock and reset.
// Expected {busy, txd} per clock is pushed to a scoreboard queue when a word is offered and popped each clock.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int NBITS = 8 + 3;
`else
    localparam int NBITS = 8 + 2;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready, txd, busy;
    logic [7:0] din1 = '0;
    logic       din_valid1 = 1'b0;
    logic       din_ready1, txd1, busy1;

    logic [1:0] expQ[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .DIV(4)) u_dut (
        .clk       (clk),
        .res       (res),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .txd       (txd),
        .busy      (busy)
    );

    serial_frame_tx #(.WIDTH(8), .DIV(1)) u_dut_div1 (
        .clk       (clk),
        .res       (res),
        .din       (din1),
        .din_valid (din_valid1),
        .din_ready (din_ready1),
        .txd       (txd1),
        .busy      (busy1)
    );

    // Reference frame: start, LSB-first data, optional even parity, stop; each level held div clocks.
    task automatic pushFrame(input logic [7:0] data, input int div);
        for (int i = 0; i < div; i++) expQ.push_back(2'b10);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < div; i++) expQ.push_back({1'b1, data[b]});
`ifdef SERIAL_FRAME_TX_PARITY_EN
        for (int i = 0; i < div; i++) expQ.push_back({1'b1, ^data});
`endif
        for (int i = 0; i < div; i++) expQ.push_back(2'b11);
    endtask

    task automatic test_reset();
        res = 1'b0;
        din = 8'hFF;
        din_valid = 1'b1;
        din1 = 8'hFF;
        din_valid1 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, txd, din_ready} !== 3'b011) begin
                errors++;
                $display("[TB] FAIL reset_hold clk%0d got busy,txd,ready=%b exp 011", c, {busy, txd, din_ready});
            end
            checks++;
            if ({busy1, txd1, din_ready1} !== 3'b011) begin
                errors++;
                $display("[TB] FAIL reset_hold_div1 clk%0d got %b exp 011", c, {busy1, txd1, din_ready1});
            end
        end
        din_valid = 1'b0;
        din_valid1 = 1'b0;
        res = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, txd, din_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL reset_release got %b exp 011", {busy, txd, din_ready});
        end
    endtask

    task automatic test_single_frame(input logic [7:0] data);
        logic [1:0] e;
        int busyClocks = 0;
        @(negedge clk);
        din = data;
        din_valid = 1'b1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_before_send got %b exp 1", din_ready);
        end
        pushFrame(data, 4);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        din = ~data;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (busy === 1'b1) busyClocks++;
            checks++;
            if ({busy, txd, din_ready} !== {e, ~e[1]}) begin
                errors++;
                $display("[TB] FAIL frame_%h got busy,txd,ready=%b exp %b", data, {busy, txd, din_ready}, {e, ~e[1]});
            end
            @(negedge clk);
        end
        checks++;
        if (busyClocks != NBITS * 4) begin
            errors++;
            $display("[TB] FAIL busy_len_%h got %0d exp %0d", data, busyClocks, NBITS * 4);
        end
        checks++;
        if ({busy, txd, din_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL idle_after_%h got %b exp 011", data, {busy, txd, din_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        int idx = 0;
        @(negedge clk);
        din = 8'h00;
        din_valid = 1'b1;
        pushFrame(8'h00, 4);
        expQ.push_back(2'b01);
        pushFrame(8'hFF, 4);
        @(posedge clk);
        @(negedge clk);
        din = 8'hFF;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if ({busy, txd, din_ready} !== {e, ~e[1]}) begin
                errors++;
                $display("[TB] FAIL b2b clk%0d got busy,txd,ready=%b exp %b", idx, {busy, txd, din_ready}, {e, ~e[1]});
            end
            if (idx == NBITS * 4 + 1) din_valid = 1'b0;
            idx++;
            @(negedge clk);
        end
        checks++;
        if ({busy, txd, din_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL b2b_idle got %b exp 011", {busy, txd, din_ready});
        end
    endtask

    task automatic test_midframe_reset();
        logic [1:0] e;
        @(negedge clk);
        din = 8'h3C;
        din_valid = 1'b1;
        pushFrame(8'h3C, 4);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        // Stop two clocks into data bit 3 (start is 4 clocks, bits 0..2 are 12 clocks).
        for (int i = 0; i < 18; i++) begin
            e = expQ.pop_front();
            checks++;
            if ({busy, txd} !== e) begin
                errors++;
                $display("[TB] FAIL pre_abort clk%0d got %b exp %b", i, {busy, txd}, e);
            end
            @(negedge clk);
        end
        expQ.delete();
        #2 res = 1'b0;
        #1;
        checks++;
        if ({busy, txd, din_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL async_abort got %b exp 011", {busy, txd, din_ready});
        end
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, txd, din_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL abort_idle got %b exp 011", {busy, txd, din_ready});
        end
    endtask

    task automatic test_div1();
        logic [1:0] e;
        int n = 0;
        @(negedge clk);
        din1 = 8'h5A;
        din_valid1 = 1'b1;
        pushFrame(8'h5A, 1);
        @(posedge clk);
        @(negedge clk);
        din_valid1 = 1'b0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (busy1 === 1'b1) n++;
            checks++;
            if ({busy1, txd1, din_ready1} !== {e, ~e[1]}) begin
                errors++;
                $display("[TB] FAIL div1 clk%0d got busy,txd,ready=%b exp %b", n, {busy1, txd1, din_ready1}, {e, ~e[1]});
            end
            @(negedge clk);
        end
        checks++;
        if (n != NBITS) begin
            errors++;
            $display("[TB] FAIL div1_len got %0d exp %0d", n, NBITS);
        end
        checks++;
        if ({busy1, txd1, din_ready1} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL div1_idle got %b exp 011", {busy1, txd1, din_ready1});
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hA5);
        test_back_to_back();
        test_midframe_reset();
        test_single_frame(8'h81);
        test_div1();
`ifdef SERIAL_FRAME_TX_PARITY_EN
        test_single_frame(8'h07);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter; the driving end for the team's D-flip-flop-based serial capture/receive logic.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it on one line, LSB-first, framed by a start bit (0) and a stop bit (1), each bit held for DIV clocks.
- Sits between a parallel producer and a single-wire serial link.

Parameters:
- WIDTH, 8, number of data bits per frame (1..32).
- DIV, 4, clocks per serial bit (>=1).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- res  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  transmitter can accept a word this cycle.
- txd  output  1  serial line; idles high.
- busy  output  1  frame in progress.

Behaviour:
- Reset (res=0, asynchronous): state=IDLE, txd=1, busy=0, din_ready=1, shift register=0, bit and tick counters=0. Reset mid-frame aborts immediately; txd goes to 1 without waiting for a clock edge.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE: din_ready=1 (decoded from state), txd=1, busy=0.
  - Handshake completes when din_valid&&din_ready at a posedge: latch din into the shift register, tick=0, go to START.
  - din_valid without din_ready is ignored; din does not need to be held after acceptance.
- START: txd=0 for DIV clocks, then go to DATA with bit_cnt=0.
- DATA: txd=shreg[0]; every DIV clocks, shift right and increment bit_cnt. After the WIDTH-th bit, go to PARITY if the parity feature is enabled, otherwise to STOP.
- STOP: txd=1 for DIV clocks, then return to IDLE.
- Outputs: txd and busy are registered. busy=1 in every non-IDLE state. din_ready=0 in every non-IDLE state.
- Latency:
  - First start-bit clock is the cycle after acceptance.
  - Frame length is (WIDTH+2)*DIV clocks, or (WIDTH+3)*DIV with parity.
  - Back-to-back frames have at least 1 IDLE clock (txd=1) between them.
- Tick counter: width $clog2(DIV) with a minimum of 1 bit. It wraps to 0 at DIV-1 and advances the state or bit. DIV=1 gives one clock per bit.
- Bit counter: width $clog2(WIDTH+1). It is never compared beyond WIDTH-1.
- Inputs are ignored while busy. A din_valid asserted in the final STOP clock is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined: the PARITY state is inserted after DATA. txd carries even parity (XOR of the latched word), computed at acceptance, for DIV clocks.
- Undefined: the PARITY state, the parity register and the parity logic are all absent; DATA goes directly to STOP.

Decomposition:
- Package serial_frame_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP; 3-bit encoding);
  - line-level constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- One sub-module, bit_tick_gen:
  - DIV-parameterised counter with clk, res and an enable (busy);
  - outputs a 1-clock tick pulse on wrap.

Test Plan:
- Reset: hold res=0 for 3 clocks, with din_valid=1 -> txd=1, busy=0, din_ready=1 throughout; no frame starts until after the res release edge.
- Single frame (WIDTH=8, DIV=4), send 0xA5 ->
  - txd: 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4;
  - busy high for exactly 40 clocks;
  - din_ready low for the same 40 clocks.
- Back-to-back 0x00 then 0xFF with din_valid held high -> second start bit begins 1 IDLE clock after the first stop bit ends; data bits are all 0, then all 1.
- Mid-frame reset: assert res=0 during data bit 3 of 0x3C -> txd=1 asynchronously; after release, state is IDLE; the next send of 0x81 produces a clean frame.
- DIV=1, send 0x5A -> 10-clock frame: 0,0,1,0,1,1,0,1,0,1.
- With SERIAL_FRAME_TX_PARITY_EN (DIV=4):
  - 0xA5 -> parity bit 0 for 4 clocks before stop;
  - 0x07 -> parity bit 1;
  - frame length 44 clocks.
